// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
// UART_RX_PARITY_EN adds the RxParity state used by the even-parity receiver build.
package uart_pkg;

    // 50 MHz system clock at 115200 baud; the transmitter uses the same default.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
`ifdef UART_RX_PARITY_EN
        RxParity,
`endif
        RxStop,
        RxBreak
    } UARTRxState;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Receive-side signals of one UART: serial line in, parsed byte and status strobes out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_in;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_start;
    logic                  rx_complete;
    logic                  rx_busy;
    logic                  frame_error;

    // master: the deserializer; slave: the pin driver and the UART component consuming bytes.
    modport master (
        input  rx_in,
        output rx_byte, rx_start, rx_complete, rx_busy, frame_error
    );

    modport slave (
        output rx_in,
        input  rx_byte, rx_start, rx_complete, rx_busy, frame_error
    );
endinterface

// File: rtl/uart_rx_deserializer_bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; flops reset to 1 so an idle UART line
// does not look like a falling edge when reset is released.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes rx_in, validates the start bit at mid-bit and samples LSB-first
// frames. Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clock,
    input  logic      reset,
    uart_rx_if.master rx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    UARTRxState            state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic                  rx_sync;
    logic                  rx_prev;
    logic                  bit_tick;
    logic                  frame_ok;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] rx_byte_q;
    logic                  rx_start_q;
    logic                  rx_complete_q;
    logic                  rx_busy_q;
    logic                  frame_error_q;

    bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx.rx_in),
        .q     (rx_sync)
    );

    assign bit_tick = (cnt == LAST_CNT);

`ifdef UART_RX_PARITY_EN
    logic parity_bit;

    function automatic logic parity_even(input logic [DATA_WIDTH-1:0] data, input logic par);
        return ^{data, par} == 1'b0;
    endfunction

    always_ff @(posedge clock) begin
        if (state == RxParity && bit_tick) begin
            parity_bit <= rx_sync;
        end
    end

    assign frame_ok = rx_sync && parity_even(shift_reg, parity_bit);
`else
    assign frame_ok = rx_sync;
`endif

    // Data bits enter at the MSB and move down, so after DATA_WIDTH samples bit 0 is the first bit sent.
    always_ff @(posedge clock) begin
        if (state == RxData && bit_tick) begin
            shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RxIdle;
            cnt           <= '0;
            bit_idx       <= '0;
            rx_prev       <= 1'b1;
            rx_byte_q     <= '0;
            rx_start_q    <= 1'b0;
            rx_complete_q <= 1'b0;
            rx_busy_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_prev       <= rx_sync;
            rx_start_q    <= 1'b0;
            rx_complete_q <= 1'b0;
            frame_error_q <= 1'b0;
            case (state)
                RxIdle: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync) state <= RxStart;
                end
                RxStart: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            state      <= RxData;
                            rx_start_q <= 1'b1;
                            rx_busy_q  <= 1'b1;
                        end else begin
                            state <= RxIdle;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= RxParity;
`else
                            state   <= RxStop;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RxParity: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= RxStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                RxStop: begin
                    if (bit_tick) begin
                        cnt       <= '0;
                        rx_busy_q <= 1'b0;
                        if (frame_ok) begin
                            rx_byte_q     <= shift_reg;
                            rx_complete_q <= 1'b1;
                            state         <= RxIdle;
                        end else begin
                            frame_error_q <= 1'b1;
                            // A low stop bit means a break; a high one with bad parity can resync at once.
                            state         <= rx_sync ? RxIdle : RxBreak;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxBreak: begin
                    if (rx_sync) state <= RxIdle;
                end
                default: state <= RxIdle;
            endcase
        end
    end

    assign rx.rx_byte     = rx_byte_q;
    assign rx.rx_start    = rx_start_q;
    assign rx.rx_complete = rx_complete_q;
    assign rx.rx_busy     = rx_busy_q;
    assign rx.frame_error = frame_error_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Builds with or without UART_RX_PARITY_EN; the parity frames are added when it is defined.
module tb_uart_rx_deserializer;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 8 * CPB + CPB + CPB;
`else
    localparam int LAT = 2 + CPB / 2 + 8 * CPB + CPB;
`endif

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   starts_seen;
    int   starts_exp;
    bit   busy_seen;
    logic [7:0] exp_last;
    exp_t sb[$];

    uart_rx_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT (CPB),
        .DATA_WIDTH   (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (rx_if.rx_start) starts_seen++;
            if (rx_if.rx_busy) busy_seen = 1'b1;
            if (rx_if.rx_complete || rx_if.frame_error) begin
                check_eq("complete_and_error_exclusive", 32'(rx_if.rx_complete & rx_if.frame_error), 0);
                if (sb.size() == 0) begin
                    check_eq("spurious_event", {30'd0, rx_if.rx_complete, rx_if.frame_error}, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("event_is_error", 32'(rx_if.frame_error), 32'(e.is_err));
                    check_eq("event_latency", cyc, e.due);
                    if (e.is_err) begin
                        check_eq("rx_byte_held", 32'(rx_if.rx_byte), 32'(exp_last));
                    end else begin
                        check_eq("rx_byte", 32'(rx_if.rx_byte), 32'(e.data));
                        exp_last = e.data;
                    end
                end
            end
        end
    end

    task automatic hold_line(input logic b, input int n);
        rx_if.rx_in = b;
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; the next posedge is the first to capture the start bit.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip);
        exp_t e;
        e.is_err = !stop || par_flip;
        e.data   = data;
        e.due    = cyc + 1 + LAT;
        sb.push_back(e);
        starts_exp++;
        hold_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_line(data[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold_line(^data ^ par_flip, CPB);
`endif
        hold_line(stop, CPB);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rx_byte"}, 32'(rx_if.rx_byte), 0);
        check_eq({tag, "_rx_start"}, 32'(rx_if.rx_start), 0);
        check_eq({tag, "_rx_complete"}, 32'(rx_if.rx_complete), 0);
        check_eq({tag, "_rx_busy"}, 32'(rx_if.rx_busy), 0);
        check_eq({tag, "_frame_error"}, 32'(rx_if.frame_error), 0);
    endtask

    initial begin
        int s0;
        cyc         = 0;
        n_checks    = 0;
        n_fail      = 0;
        starts_seen = 0;
        starts_exp  = 0;
        busy_seen   = 1'b0;
        exp_last    = 8'h00;
        reset       = 1'b1;
        rx_if.rx_in = 1'b1;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        hold_line(1'b1, 2 * CPB);

        send_frame(8'h55, 1'b1, 1'b0);
        hold_line(1'b1, CPB);

        // Short low pulse must be rejected at the start-bit mid-sample.
        s0        = starts_seen;
        busy_seen = 1'b0;
        hold_line(1'b0, 3);
        hold_line(1'b1, 3 * CPB);
        check_eq("glitch_rx_start", starts_seen - s0, 0);
        check_eq("glitch_rx_busy", 32'(busy_seen), 0);

        // Framing error followed by a long break, then a normal frame.
        send_frame(8'hA3, 1'b0, 1'b0);
        hold_line(1'b0, 40 * CPB);
        hold_line(1'b1, 2 * CPB);
        send_frame(8'h3C, 1'b1, 1'b0);
        hold_line(1'b1, CPB);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        hold_line(1'b1, 2 * CPB);

        // Reset in the middle of the data bits of 0x7E; the partial frame must vanish.
        starts_exp++;
        hold_line(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold_line(i == 0 ? 1'b0 : 1'b1, CPB);
        check_eq("mid_frame_rx_busy", 32'(rx_if.rx_busy), 1);
        rx_if.rx_in = 1'b1;
        reset       = 1'b1;
        exp_last    = 8'h00;
        #1;
        check_idle_outputs("mid_reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        hold_line(1'b1, 2 * CPB);
        send_frame(8'h12, 1'b1, 1'b0);
        hold_line(1'b1, CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        hold_line(1'b1, CPB);
        send_frame(8'h07, 1'b1, 1'b1);
        hold_line(1'b1, CPB);
`endif

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clock);
        check_eq("scoreboard_drained", sb.size(), 0);
        check_eq("rx_start_count", starts_seen, starts_exp);
        check_eq("final_rx_busy", 32'(rx_if.rx_busy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
